// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: PC, instruction-memory handshake, pipeline hazard controls and perf counters.
// master = fetch_ctrl side, slave = PC register / memory / hazard unit side.
interface fetch_ctrl_if;
    logic [31:0] pc_f;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr_f;
    logic        hazard_stall_d;
    logic        pc_src_d;
    logic        jump_d;
    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_wait_cnt;

    // Handshake: imem_req stays high with a stable imem_addr until the cycle
    // imem_ready is seen; imem_ready with imem_req low carries no meaning.
    modport master (
        input  pc_f, imem_ready, imem_rdata, hazard_stall_d, pc_src_d, jump_d,
        output imem_req, imem_addr, instr_f, stall_f, stall_d, flush_d, flush_e,
               perf_fetch_cnt, perf_wait_cnt
    );

    modport slave (
        output pc_f, imem_ready, imem_rdata, hazard_stall_d, pc_src_d, jump_d,
        input  imem_req, imem_addr, instr_f, stall_f, stall_d, flush_d, flush_e,
               perf_fetch_cnt, perf_wait_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues instruction fetches, buffers a word across load-use stalls,
// and drives PC/F-D/D-E stall and flush controls. Optional counters: FETCH_CTRL_PERF_EN.
module fetch_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d, state_cur;
    logic [31:0] buf_q, buf_d;
    logic        redirect;
    logic        hz;
    logic        rdy;

    assign redirect = bus.pc_src_d | bus.jump_d;
    assign hz       = bus.hazard_stall_d;
    assign rdy      = bus.imem_ready;

    // While reset is asserted the outputs already look like BOOT, so a
    // pending response is never presented to the pipeline.
    always_comb begin
        state_cur = rst_n ? state_q : BOOT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d       = state_cur;
        buf_d         = buf_q;
        bus.imem_req  = 1'b0;
        bus.imem_addr = bus.pc_f;
        bus.instr_f   = '0;
        bus.stall_f   = 1'b1;
        bus.stall_d   = 1'b0;
        bus.flush_d   = 1'b1;
        bus.flush_e   = 1'b0;
        case (state_cur)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                bus.instr_f  = bus.imem_rdata;
                bus.stall_f  = hz | ~rdy;
                bus.stall_d  = hz | (redirect & ~rdy);
                bus.flush_e  = hz | (redirect & ~rdy);
                bus.flush_d  = ~hz & (redirect ? rdy : ~rdy);
                // Word arrived but D cannot take it: park it until the stall clears.
                if (rdy && hz) begin
                    buf_d   = bus.imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                bus.instr_f = buf_q;
                bus.stall_f = hz;
                bus.stall_d = hz;
                bus.flush_e = hz;
                bus.flush_d = ~hz & redirect;
                if (!hz) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign state_o = state_cur;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (state_cur == FETCH) begin
            if (rdy) begin
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end else begin
                wait_cnt_d = wait_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_q;
    assign bus.perf_wait_cnt  = wait_cnt_q;
`else
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand sequences for wait/reset corners,
// then random traffic against a queue-based reference model.
module tb_fetch_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_o;

    fetch_ctrl_if bus ();

    fetch_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: "booting" flag, a queue holding the parked word, counts.
    logic        m_boot;
    logic [31:0] m_hold_q[$];
    logic [31:0] m_fetch_cnt;
    logic [31:0] m_wait_cnt;

    logic        e_req, e_sf, e_sd, e_fd, e_fe;
    logic [31:0] e_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef FETCH_CTRL_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Expected outputs for this cycle from the model state and the driven inputs.
    task automatic model_eval();
        logic redir;
        redir = bus.pc_src_d | bus.jump_d;
        e_instr = '0;
        if (!rst_n || m_boot) begin
            e_req = 0; e_sf = 1; e_sd = 0; e_fd = 1; e_fe = 0;
        end else if (m_hold_q.size() > 0) begin
            e_req = 0;
            e_instr = m_hold_q[0];
            e_sf = bus.hazard_stall_d; e_sd = bus.hazard_stall_d; e_fe = bus.hazard_stall_d;
            e_fd = !bus.hazard_stall_d && redir;
        end else begin
            e_req = 1;
            e_instr = bus.imem_rdata;
            if (bus.hazard_stall_d) begin
                // load-use stall freezes F and D, bubbles E, ignores redirect
                e_sf = 1; e_sd = 1; e_fe = 1; e_fd = 0;
            end else if (redir) begin
                // redirect waits for the outstanding word, then squashes it
                e_sf = !bus.imem_ready; e_sd = !bus.imem_ready; e_fe = !bus.imem_ready;
                e_fd = bus.imem_ready;
            end else begin
                e_sf = !bus.imem_ready; e_sd = 0; e_fe = 0;
                e_fd = !bus.imem_ready;
            end
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            m_boot = 1;
            m_hold_q.delete();
            m_fetch_cnt = 0;
            m_wait_cnt = 0;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_hold_q.size() > 0) begin
            if (!bus.hazard_stall_d) void'(m_hold_q.pop_front());
        end else begin
            if (bus.imem_ready) m_fetch_cnt = m_fetch_cnt + 1;
            else m_wait_cnt = m_wait_cnt + 1;
            if (bus.imem_ready && bus.hazard_stall_d) m_hold_q.push_back(bus.imem_rdata);
        end
    endtask

    // Called just after a posedge: drive, settle, compute expectations.
    task automatic apply(input logic r, input logic rdy, input logic haz,
                         input logic src, input logic jmp, input logic [31:0] rd);
        rst_n = r;
        bus.imem_ready = rdy;
        bus.hazard_stall_d = haz;
        bus.pc_src_d = src;
        bus.jump_d = jmp;
        bus.imem_rdata = rd;
        #3;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".req"},   {31'd0, bus.imem_req}, {31'd0, e_req});
        chk({tag, ".sf"},    {31'd0, bus.stall_f},  {31'd0, e_sf});
        chk({tag, ".sd"},    {31'd0, bus.stall_d},  {31'd0, e_sd});
        chk({tag, ".fd"},    {31'd0, bus.flush_d},  {31'd0, e_fd});
        chk({tag, ".fe"},    {31'd0, bus.flush_e},  {31'd0, e_fe});
        chk({tag, ".instr"}, bus.instr_f, e_instr);
        chk({tag, ".addr"},  bus.imem_addr, bus.pc_f);
        chk({tag, ".pfetch"}, bus.perf_fetch_cnt, perf_exp(m_fetch_cnt));
        chk({tag, ".pwait"},  bus.perf_wait_cnt,  perf_exp(m_wait_cnt));
    endtask

    typedef struct {
        logic        rdy, haz, src, jmp;
        logic [31:0] rd;
        logic        req, sf, sd, fd, fe;
        logic [31:0] instr;
        logic [1:0]  st;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic haz, input logic src,
                                input logic jmp, input logic [31:0] rd,
                                input logic req, input logic sf, input logic sd,
                                input logic fd, input logic fe,
                                input logic [31:0] instr, input logic [1:0] st);
        vec_t v;
        v.rdy = rdy; v.haz = haz; v.src = src; v.jmp = jmp; v.rd = rd;
        v.req = req; v.sf = sf; v.sd = sd; v.fd = fd; v.fe = fe;
        v.instr = instr; v.st = st;
        return v;
    endfunction

    vec_t vecs[14];

    initial begin
        logic [31:0] w0;
        logic [31:0] pc;

        //            rdy haz src jmp rdata          req sf sd fd fe instr         st
        vecs[0]  = mk(1, 0, 0, 0, 32'h1111_1111,     0, 1, 0, 1, 0, 32'h0,         2'd0);
        vecs[1]  = mk(1, 0, 0, 0, 32'h2222_2222,     1, 0, 0, 0, 0, 32'h2222_2222, 2'd1);
        vecs[2]  = mk(0, 0, 0, 0, 32'h3333_3333,     1, 1, 0, 1, 0, 32'h3333_3333, 2'd1);
        vecs[3]  = mk(1, 1, 0, 0, 32'h8C22_0004,     1, 1, 1, 0, 1, 32'h8C22_0004, 2'd1);
        vecs[4]  = mk(0, 1, 0, 0, 32'hDEAD_BEEF,     0, 1, 1, 0, 1, 32'h8C22_0004, 2'd2);
        vecs[5]  = mk(1, 0, 0, 0, 32'hDEAD_BEEF,     0, 0, 0, 0, 0, 32'h8C22_0004, 2'd2);
        vecs[6]  = mk(0, 0, 1, 0, 32'h4444_4444,     1, 1, 1, 0, 1, 32'h4444_4444, 2'd1);
        vecs[7]  = mk(0, 0, 1, 0, 32'h4444_4444,     1, 1, 1, 0, 1, 32'h4444_4444, 2'd1);
        vecs[8]  = mk(1, 0, 1, 0, 32'h5555_5555,     1, 0, 0, 1, 0, 32'h5555_5555, 2'd1);
        vecs[9]  = mk(0, 1, 1, 0, 32'h6666_6666,     1, 1, 1, 0, 1, 32'h6666_6666, 2'd1);
        vecs[10] = mk(1, 0, 0, 1, 32'h7777_7777,     1, 0, 0, 1, 0, 32'h7777_7777, 2'd1);
        vecs[11] = mk(1, 1, 0, 0, 32'h9999_9999,     1, 1, 1, 0, 1, 32'h9999_9999, 2'd1);
        vecs[12] = mk(0, 0, 1, 0, 32'h0000_0000,     0, 0, 0, 1, 0, 32'h9999_9999, 2'd2);
        vecs[13] = mk(1, 0, 0, 0, 32'hAAAA_AAAA,     1, 0, 0, 0, 0, 32'hAAAA_AAAA, 2'd1);

        m_boot = 1; m_fetch_cnt = 0; m_wait_cnt = 0;
        bus.pc_f = 32'h0000_1000;

        // Reset for two cycles, checking BOOT outputs while rst_n is low.
        @(posedge clk); #1;
        apply(0, 1, 0, 0, 0, 32'h0);
        chk("rst.req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst.sf",  {31'd0, bus.stall_f},  32'd1);
        advance();
        apply(0, 1, 0, 0, 0, 32'h0);
        advance();

        for (int i = 0; i < 14; i++) begin
            apply(1, vecs[i].rdy, vecs[i].haz, vecs[i].src, vecs[i].jmp, vecs[i].rd);
            chk($sformatf("vec%0d.req", i),   {31'd0, bus.imem_req}, {31'd0, vecs[i].req});
            chk($sformatf("vec%0d.sf", i),    {31'd0, bus.stall_f},  {31'd0, vecs[i].sf});
            chk($sformatf("vec%0d.sd", i),    {31'd0, bus.stall_d},  {31'd0, vecs[i].sd});
            chk($sformatf("vec%0d.fd", i),    {31'd0, bus.flush_d},  {31'd0, vecs[i].fd});
            chk($sformatf("vec%0d.fe", i),    {31'd0, bus.flush_e},  {31'd0, vecs[i].fe});
            chk($sformatf("vec%0d.instr", i), bus.instr_f, vecs[i].instr);
            chk($sformatf("vec%0d.state", i), {30'd0, state_o}, {30'd0, vecs[i].st});
            chk($sformatf("vec%0d.pwait", i), bus.perf_wait_cnt, perf_exp(m_wait_cnt));
            advance();
        end

        // Three-cycle memory wait at 0x40: address held, F stalled, D bubbled.
        bus.pc_f = 32'h0000_0040;
        w0 = bus.perf_wait_cnt;
        for (int i = 0; i < 3; i++) begin
            apply(1, 0, 0, 0, 0, 32'h0);
            chk($sformatf("wait%0d.req", i),  {31'd0, bus.imem_req}, 32'd1);
            chk($sformatf("wait%0d.sf", i),   {31'd0, bus.stall_f},  32'd1);
            chk($sformatf("wait%0d.fd", i),   {31'd0, bus.flush_d},  32'd1);
            chk($sformatf("wait%0d.addr", i), bus.imem_addr, 32'h0000_0040);
            advance();
        end
        chk("wait.delta", bus.perf_wait_cnt - w0, perf_exp(32'd3));
        apply(1, 1, 0, 0, 0, 32'h1234_5678);
        chk("wait.done.sf", {31'd0, bus.stall_f}, 32'd0);
        advance();

        // Reset lands while a request is outstanding.
        apply(1, 0, 0, 0, 0, 32'h0);
        chk("midrst.pre.req", {31'd0, bus.imem_req}, 32'd1);
        advance();
        apply(0, 1, 0, 0, 0, 32'hCAFE_F00D);
        chk("midrst.during.req", {31'd0, bus.imem_req}, 32'd0);
        advance();
        apply(1, 1, 0, 0, 0, 32'hCAFE_F00D);
        chk("midrst.after.state",  {30'd0, state_o}, 32'd0);
        chk("midrst.after.req",    {31'd0, bus.imem_req}, 32'd0);
        chk("midrst.after.pfetch", bus.perf_fetch_cnt, 32'd0);
        chk("midrst.after.pwait",  bus.perf_wait_cnt, 32'd0);
        advance();
        apply(1, 1, 0, 0, 0, 32'hCAFE_F00D);
        chk("midrst.fetch.req",   {31'd0, bus.imem_req}, 32'd1);
        chk("midrst.fetch.instr", bus.instr_f, 32'hCAFE_F00D);
        advance();

        // Random traffic against the model; PC moves only when F is not stalled.
        pc = 32'h0000_2000;
        for (int i = 0; i < 400; i++) begin
            bus.pc_f = pc;
            apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0), $urandom);
            chk_model($sformatf("rnd%0d", i));
            if (!e_sf && rst_n) begin
                if (bus.pc_src_d || bus.jump_d) pc = {$urandom_range(0, 32'h3FFF), 2'b00};
                else pc = pc + 32'd4;
            end
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
